banked_data_mem: RTL

BANKED_DATA_MEM -- requirements
Module: banked_data_mem

---
 rtl/banked_data_mem_pkg.sv | 24 ++
 rtl/banked_data_mem_mem_bank.sv | 30 +++
 rtl/banked_data_mem.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/banked_data_mem_pkg.sv
// Shared definitions for banked_data_mem: access-size encodings, FSM states
// and the lane-count legality check used at elaboration.
// Latency: n/a (types only). Backpressure: n/a.
package banked_data_mem_pkg;

  // req_size encodings; SZ_BAD is always rejected with an error response.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Only power-of-two lane counts 2, 4 and 8 are supported.
  function automatic bit lanes_legal(input int lanes);
    return (lanes == 2) || (lanes == 4) || (lanes == 8);
  endfunction

endpackage

// File: rtl/banked_data_mem_mem_bank.sv
// One byte lane of banked_data_mem: byte-wide, ROWS-deep synchronous RAM.
// Latency: read data 1 cycle after the address is presented (read-old on write).
// Backpressure: none; accepts a read or write every cycle.
// Ports: clk, i_we (write enable), i_addr (row), i_wdat (write byte), o_rdat (read byte).
module mem_bank
  import banked_data_mem_pkg::*;
#(
  parameter int ROWS  = 64,
  parameter int ROW_W = 6
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [ROW_W-1:0] i_addr,
  input  logic [7:0]       i_wdat,
  output logic [7:0]       o_rdat
);

  logic [7:0] r_mem [ROWS];
  logic [7:0] r_rdat;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdat;
    end
    r_rdat <= r_mem[i_addr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/banked_data_mem.sv
// Byte-addressed data memory built from LANES byte-wide banks; handles byte/half/word
// loads and stores, unaligned ones either split across two rows or rejected.
// Latency: load/error response 1 cycle after acceptance. Backpressure: req_ready low only
// during the post-reset clear sweep (ROWS cycles); full throughput afterwards.
// Ports: clk, rst_n (sync, active-low); req_* request channel (valid/ready, write, size,
// signed, addr, wdata); resp_valid/resp_rdata/resp_err response; init_done after clear sweep.
module banked_data_mem
  import banked_data_mem_pkg::*;
#(
  parameter int LANES         = 4,
  parameter int ADDR_W        = 8,
  parameter int MISALIGN_MODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [8*LANES-1:0] req_wdata,
  output logic               resp_valid,
  output logic [8*LANES-1:0] resp_rdata,
  output logic               resp_err,
  output logic               init_done
);

  localparam int OFF_W  = $clog2(LANES);
  localparam int ROW_W  = ADDR_W - OFF_W;
  localparam int ROWS   = (1 << ADDR_W) / LANES;
  localparam int DATA_W = 8 * LANES;
  localparam int N_W    = OFF_W + 1;  // holds a byte count up to LANES
  localparam bit LANES_OK = lanes_legal(LANES);

  if (!LANES_OK) begin : g_bad_lanes
    $error("banked_data_mem: LANES must be 2, 4 or 8");
  end

  state_e           r_state;
  logic [ROW_W-1:0] r_cnt;
  logic             r_init_done;
  logic             r_pend;
  logic             r_err;
  logic [OFF_W-1:0] r_off;
  logic [N_W-1:0]   r_n;
  logic             r_sgn;

  logic [OFF_W-1:0] w_off;
  logic [ROW_W-1:0] w_row;
  logic [N_W-1:0]   w_n;
  logic             w_mis;
  logic             w_err;
  logic             w_acc;
  logic             w_st;
  logic [7:0]       w_rdat [LANES];
  logic [DATA_W-1:0] w_raw;
  logic [DATA_W-1:0] w_ext;
  logic             w_sign;

  // ---------------- request decode ----------------
  assign w_off = req_addr[OFF_W-1:0];
  assign w_row = req_addr[ADDR_W-1:OFF_W];

  always_comb begin
    w_n = N_W'(LANES);
    case (req_size)
      SZ_BYTE: w_n = N_W'(1);
      SZ_HALF: w_n = N_W'(2);
      default: w_n = N_W'(LANES);
    endcase
  end

  // n is a power of two, so "o mod n != 0" is a mask test. For a full word the
  // low OFF_W bits of n are zero and n-1 becomes all ones: any nonzero offset.
  assign w_mis = (w_off & (w_n[OFF_W-1:0] - OFF_W'(1))) != '0;
  assign w_err = (req_size == SZ_BAD) || ((MISALIGN_MODE != 0) && w_mis);
  assign w_acc = req_valid && (r_state == ST_RUN);
  assign w_st  = w_acc && req_write && !w_err;

  // ---------------- lanes ----------------
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [OFF_W-1:0] w_idx;   // which byte of the access lands in this lane
    logic             w_hit;
    logic [ROW_W-1:0] w_addr;
    logic             w_we;
    logic [7:0]       w_wdat;

    assign w_idx = OFF_W'(l) - w_off;
    assign w_hit = {1'b0, w_idx} < w_n;
    // Lanes below the offset hold the bytes that spilled past the row end, so
    // they use the next row; the top row wraps to row 0 by natural overflow.
    assign w_addr = (r_state == ST_INIT)  ? r_cnt :
                    (OFF_W'(l) >= w_off)  ? w_row : w_row + ROW_W'(1);
    assign w_we   = (r_state == ST_INIT) || (w_st && w_hit);
    assign w_wdat = (r_state == ST_INIT) ? 8'h00 : req_wdata[{w_idx, 3'b000} +: 8];

    mem_bank #(
      .ROWS  (ROWS),
      .ROW_W (ROW_W)
    ) u_bank (
      .clk    (clk),
      .i_we   (w_we),
      .i_addr (w_addr),
      .i_wdat (w_wdat),
      .o_rdat (w_rdat[l])
    );
  end

  // ---------------- response reassembly ----------------
  // Uses offset/size/sign captured at acceptance, aligned with the bank read data.
  always_comb begin
    w_raw  = '0;
    w_sign = 1'b0;
    w_ext  = '0;
    for (int i = 0; i < LANES; i++) begin
      w_raw[8*i +: 8] = w_rdat[r_off + OFF_W'(i)];
    end
    for (int i = 0; i < LANES; i++) begin
      if (N_W'(i) == (r_n - N_W'(1))) begin
        w_sign = w_raw[8*i+7];
      end
    end
    for (int i = 0; i < LANES; i++) begin
      w_ext[8*i +: 8] = (N_W'(i) < r_n) ? w_raw[8*i +: 8] : {8{r_sgn & w_sign}};
    end
  end

  // ---------------- FSM and response state ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_pend      <= 1'b0;
      r_err       <= 1'b0;
      r_off       <= '0;
      r_n         <= '0;
      r_sgn       <= 1'b0;
    end else begin
      r_pend <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + ROW_W'(1);
          if (r_cnt == ROW_W'(ROWS - 1)) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_acc) begin
            // Stores respond only when rejected.
            r_pend <= !req_write || w_err;
            r_err  <= w_err;
            r_off  <= w_off;
            r_n    <= w_n;
            r_sgn  <= req_signed;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_RUN);
  assign init_done  = r_init_done;
  assign resp_valid = r_pend;
  assign resp_err   = r_err;
  assign resp_rdata = (r_pend && !r_err) ? w_ext : '0;

endmodule
